seg_dis_driver: RTL and testbench
=================================

SEG_DIS_DRIVER -- requirements
Module: seg_dis_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clk cycles per digit scan slot; legal range >= 2.
REQ-002 SHALL have port clk, input, 1; the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-004 SHALL have port core_dis_data, input, 8; unsigned distance byte written by the CPU peripheral block.
REQ-005 SHALL have port core_dis_data_wr, input, 1; one-clk write strobe qualifying core_dis_data.
REQ-006 SHALL have port seg_sel, output, 4; registered, active-low digit enables; bit0 = units.
REQ-007 SHALL have port seg_data, output, 8; registered, active-low segments; [6:0] = g..a, [7] = dp (always 1).
REQ-008 SHALL have port dis_busy, output, 1; registered; high while a conversion is in progress or pending.

Function
REQ-009 SHALL sample core_dis_data on the clk edge where core_dis_data_wr = 1 (edge N).
REQ-010 SHALL convert when idle: dis_busy = 1 from edge N; 8 double-dabble iterations, one per clk.
REQ-011 SHALL load the 3-digit BCD display register at edge N+8; dis_busy falls at the same edge unless a value is pending.
REQ-012 SHALL capture a strobe arriving while busy into a 1-entry pending register; a later strobe overwrites it (last wins).
REQ-013 SHALL start the pending conversion on the completion edge; dis_busy stays high with no gap.
REQ-014 SHALL hold the display register during conversion, so the previous value stays visible until the new result loads.
REQ-015 SHALL advance the prescaler every clk; at count SCAN_DIV-1 it wraps to 0 and the digit index steps 0->1->2->3->0.
REQ-016 SHALL register seg_sel with exactly one bit low (the bit at the digit index) and update seg_data in the same cycle.
REQ-017 SHALL drive digit 0 = units, 1 = tens, 2 = hundreds and 3 = always blank (8'hFF).
REQ-018 SHALL use seg_data codes 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90 (hex); blank = FF.
REQ-019 SHALL ignore core_dis_data_wr asserted in the same cycle as reset release; no other input qualification is applied.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set seg_sel = 4'b1111, seg_data = 8'hFF, dis_busy = 0, display register = 0, pending cleared, prescaler = 0 and digit index = 0.
REQ-021 SHALL discard any conversion or pending value in progress when reset is asserted mid-operation.
REQ-022 SHALL output digit 0 at the first clk after reset release: seg_sel = 4'b1110, seg_data = C0.

Configuration
REQ-023 SHALL, with SEG_ZERO_BLANK_EN defined, blank the hundreds digit when it is 0, and blank the tens digit when hundreds and tens are both 0; units are never blanked.
REQ-024 SHALL, without SEG_ZERO_BLANK_EN, display all three digits, including leading zeros (C0).

Structure
REQ-025 SHALL place the segment code constants, the blank code, the digit count (4) and the BCD width (12) in package seg_dis_pkg.
REQ-026 SHALL implement the sequential double-dabble converter as sub-module bin2bcd_seq (start, 8-bit in, done, 12-bit BCD out).

Verification
REQ-027 SHALL cover: write 8'd123 -> dis_busy high 8 clks; then digits 0/1/2/3 = B0/A4/F9/FF.
REQ-028 SHALL cover: write 8'd7 -> with SEG_ZERO_BLANK_EN digits = F8/FF/FF/FF; without the macro = F8/C0/C0/FF.
REQ-029 SHALL cover: write 200, then 45 and 99 while busy -> dis_busy held continuously; the display passes 200 then 99; 45 is never shown.
REQ-030 SHALL cover: SCAN_DIV = 4 -> seg_sel = 1110,1101,1011,0111,1110, each held 4 clks.
REQ-031 SHALL cover: rst_n low at clk 4 of a 255 conversion -> outputs at reset values; after release the display shows 0 (C0 on units) and dis_busy = 0.
REQ-032 SHALL cover: write 8'd255 then 8'd0 spaced 20 clks -> 255 shows 92/92/A4 and 0 shows C0 on units.

Source files
------------

// File: rtl/seg_dis_pkg.sv
// Shared constants for the distance display driver: segment codes, digit count,
// BCD width, and the segment encoder / double-dabble adjust helpers.
package seg_dis_pkg;

    localparam int DIGIT_CNT  = 4;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 12;
    localparam int BIN_W      = 8;

    // Active-low segment codes, bit7 = dp (kept off), [6:0] = g..a
    localparam logic [7:0] SEG_CODE_0 = 8'hC0;
    localparam logic [7:0] SEG_CODE_1 = 8'hF9;
    localparam logic [7:0] SEG_CODE_2 = 8'hA4;
    localparam logic [7:0] SEG_CODE_3 = 8'hB0;
    localparam logic [7:0] SEG_CODE_4 = 8'h99;
    localparam logic [7:0] SEG_CODE_5 = 8'h92;
    localparam logic [7:0] SEG_CODE_6 = 8'h82;
    localparam logic [7:0] SEG_CODE_7 = 8'hF8;
    localparam logic [7:0] SEG_CODE_8 = 8'h80;
    localparam logic [7:0] SEG_CODE_9 = 8'h90;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    function automatic logic [7:0] seg_encode(input logic [3:0] bcd);
        logic [7:0] code;
        case (bcd)
            4'd0:    code = SEG_CODE_0;
            4'd1:    code = SEG_CODE_1;
            4'd2:    code = SEG_CODE_2;
            4'd3:    code = SEG_CODE_3;
            4'd4:    code = SEG_CODE_4;
            4'd5:    code = SEG_CODE_5;
            4'd6:    code = SEG_CODE_6;
            4'd7:    code = SEG_CODE_7;
            4'd8:    code = SEG_CODE_8;
            4'd9:    code = SEG_CODE_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one shift per clock.
// The start edge performs the first shift; done pulses one cycle after the eighth.
module bin2bcd_seq
    import seg_dis_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] bcd_adj_s;

    // Next-state for the shift/adjust datapath
    always_comb begin
        bcd_adj_s = dd_adjust(bcd_q);
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        done_d    = 1'b0;
        if (start_i) begin
            // With an all-zero BCD register no adjust is needed before the first shift
            bcd_d   = {{(BCD_W-1){1'b0}}, bin_i[BIN_W-1]};
            shift_d = bin_i << 1;
            cnt_d   = 3'd1;
            run_d   = 1'b1;
        end else if (run_q) begin
            bcd_d   = (bcd_adj_s << 1) | {{(BCD_W-1){1'b0}}, shift_q[BIN_W-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= {BIN_W{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
            cnt_q   <= 3'd0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_dis_driver.sv
// Distance byte to multiplexed 4-digit 7-segment display (units/tens/hundreds/blank).
// Define SEG_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module seg_dis_driver
    import seg_dis_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_W-1:0]     core_dis_data,
    input  logic                 core_dis_data_wr,
    output logic [DIGIT_CNT-1:0] seg_sel,
    output logic [7:0]           seg_data,
    output logic                 dis_busy
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);

    logic                 arm_q;
    logic                 busy_q, busy_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [BIN_W-1:0]     pend_data_q, pend_data_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [1:0]           digit_q, digit_d;
    logic [DIGIT_CNT-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]           seg_data_q, seg_data_d;

    logic                 wr_s;
    logic                 start_s;
    logic [BIN_W-1:0]     start_data_s;
    logic                 conv_done_s;
    logic [BCD_W-1:0]     conv_bcd_s;
    logic                 hund_blank_s;
    logic                 tens_blank_s;

    // A strobe coinciding with the first edge after reset release is dropped
    assign wr_s = core_dis_data_wr & arm_q;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_s),
        .bin_i   (start_data_s),
        .done_o  (conv_done_s),
        .bcd_o   (conv_bcd_s)
    );

    // Conversion control: start when idle, park one pending value while busy
    always_comb begin
        start_s      = 1'b0;
        start_data_s = core_dis_data;
        busy_d       = busy_q;
        pend_vld_d   = pend_vld_q;
        pend_data_d  = pend_data_q;
        disp_d       = disp_q;
        if (conv_done_s) begin
            disp_d     = conv_bcd_s;
            pend_vld_d = 1'b0;
            // A strobe on the completion edge is newer than anything pending
            if (wr_s) begin
                start_s      = 1'b1;
                start_data_s = core_dis_data;
                busy_d       = 1'b1;
            end else if (pend_vld_q) begin
                start_s      = 1'b1;
                start_data_s = pend_data_q;
                busy_d       = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end else if (busy_q) begin
            if (wr_s) begin
                pend_vld_d  = 1'b1;
                pend_data_d = core_dis_data;
            end else begin
                pend_vld_d  = pend_vld_q;
            end
        end else begin
            if (wr_s) begin
                start_s = 1'b1;
                busy_d  = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

`ifdef SEG_ZERO_BLANK_EN
    assign hund_blank_s = (disp_q[11:8] == 4'd0);
    assign tens_blank_s = hund_blank_s & (disp_q[7:4] == 4'd0);
`else
    assign hund_blank_s = 1'b0;
    assign tens_blank_s = 1'b0;
`endif

    // Scan prescaler, digit index and next segment outputs
    always_comb begin
        if (presc_q == PRESC_MAX) begin
            presc_d = {PW{1'b0}};
            digit_d = digit_q + 2'd1;
        end else begin
            presc_d = presc_q + PRESC_ONE;
            digit_d = digit_q;
        end
        seg_sel_d = ~(4'b0001 << digit_q);
        case (digit_q)
            2'd0:    seg_data_d = seg_encode(disp_q[3:0]);
            2'd1:    seg_data_d = tens_blank_s ? SEG_BLANK : seg_encode(disp_q[7:4]);
            2'd2:    seg_data_d = hund_blank_s ? SEG_BLANK : seg_encode(disp_q[11:8]);
            2'd3:    seg_data_d = SEG_BLANK;
            default: seg_data_d = SEG_BLANK;
        endcase
    end

    // Control, display and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q       <= 1'b0;
            busy_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= {BIN_W{1'b0}};
            disp_q      <= {BCD_W{1'b0}};
            presc_q     <= {PW{1'b0}};
            digit_q     <= 2'd0;
            seg_sel_q   <= 4'b1111;
            seg_data_q  <= SEG_BLANK;
        end else begin
            arm_q       <= 1'b1;
            busy_q      <= busy_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            disp_q      <= disp_d;
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            seg_sel_q   <= seg_sel_d;
            seg_data_q  <= seg_data_d;
        end
    end

    assign seg_sel  = seg_sel_q;
    assign seg_data = seg_data_q;
    assign dis_busy = busy_q;

endmodule

// File: tb/tb_seg_dis_driver.sv
// Scoreboard bench for seg_dis_driver with SCAN_DIV = 4: expected digit slots are
// queued by the stimulus and popped by a monitor on every digit change.
module tb_seg_dis_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] core_dis_data = 8'd0;
    logic       core_dis_data_wr = 1'b0;
    logic [3:0] seg_sel;
    logic [7:0] seg_data;
    logic       dis_busy;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       care;
        logic [3:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] prev_sel = 4'b1111;

`ifdef SEG_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_dis_driver #(.SCAN_DIV(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .core_dis_data    (core_dis_data),
        .core_dis_data_wr (core_dis_data_wr),
        .seg_sel          (seg_sel),
        .seg_data         (seg_data),
        .dis_busy         (dis_busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: each new digit slot pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (seg_sel !== prev_sel && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot_sel", {4'h0, seg_sel}, {4'h0, e.sel});
            if (e.care) check("slot_data", seg_data, e.data);
        end
        prev_sel = seg_sel;
    end

    task automatic push(input logic care, input logic [3:0] sel, input logic [7:0] data);
        exp_t e;
        e.care = care;
        e.sel  = sel;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_sel(input logic [3:0] v, input bit want_eq);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((seg_sel == v) != want_eq) && n < 200);
        if (n >= 200) timeout_fail("wait_sel");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("drain");
    endtask

    // Sync to the start of the blank slot, then queue one full scan
    task automatic check_disp(input logic [7:0] u, input logic [7:0] t, input logic [7:0] h);
        wait_sel(4'b0111, 1'b0);
        wait_sel(4'b0111, 1'b1);
        @(posedge clk);
        push(1'b1, 4'b1110, u);
        push(1'b1, 4'b1101, t);
        push(1'b1, 4'b1011, h);
        push(1'b1, 4'b0111, 8'hFF);
        wait_drain();
    endtask

    // Called at a negedge; the following posedge is the write edge
    task automatic write(input logic [7:0] v);
        core_dis_data    = v;
        core_dis_data_wr = 1'b1;
        @(negedge clk);
        core_dis_data_wr = 1'b0;
    endtask

    task automatic busy_window();
        for (int i = 0; i < 8; i++) begin
            check("busy_high", {7'd0, dis_busy}, 8'd1);
            @(negedge clk);
        end
        check("busy_low", {7'd0, dis_busy}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] one;
        logic [3:0] esel;
        one = 4'b0001;
        repeat (2) @(negedge clk);
        check("rst_sel", {4'h0, seg_sel}, 8'h0F);
        check("rst_data", seg_data, 8'hFF);
        check("rst_busy", {7'd0, dis_busy}, 8'd0);

        // Strobe during the release cycle must be ignored
        rst_n = 1'b1;
        write(8'd55);
        check("first_sel", {4'h0, seg_sel}, 8'h0E);
        check("first_data", seg_data, 8'hC0);
        check("rel_wr_ignored", {7'd0, dis_busy}, 8'd0);

        for (int k = 1; k <= 20; k++) begin
            esel = ~(one << (((k - 1) / 4) % 4));
            check("scan_sel", {4'h0, seg_sel}, {4'h0, esel});
            @(negedge clk);
        end

        write(8'd123);
        busy_window();
        check_disp(8'hB0, 8'hA4, 8'hF9);

        write(8'd7);
        busy_window();
        check_disp(8'hF8, ZB ? 8'hFF : 8'hC0, ZB ? 8'hFF : 8'hC0);

        write(8'd255);
        busy_window();
        check_disp(8'h92, 8'h92, 8'hA4);
        repeat (4) @(negedge clk);
        write(8'd0);
        busy_window();
        check_disp(8'hC0, ZB ? 8'hFF : 8'hC0, ZB ? 8'hFF : 8'hC0);

        // 200 then 45, 99 while busy: 200's tens/hundreds seen, then 99, never 45
        wait_sel(4'b0111, 1'b0);
        wait_sel(4'b0111, 1'b1);
        @(posedge clk);
        push(1'b0, 4'b1110, 8'h00);
        push(1'b0, 4'b1101, 8'h00);
        push(1'b0, 4'b1011, 8'h00);
        push(1'b1, 4'b0111, 8'hFF);
        push(1'b0, 4'b1110, 8'h00);
        push(1'b1, 4'b1101, 8'hC0);
        push(1'b1, 4'b1011, 8'hA4);
        push(1'b1, 4'b0111, 8'hFF);
        push(1'b1, 4'b1110, 8'h90);
        push(1'b1, 4'b1101, 8'h90);
        push(1'b1, 4'b1011, ZB ? 8'hFF : 8'hC0);
        push(1'b1, 4'b0111, 8'hFF);
        wait_sel(4'b1110, 1'b1);
        repeat (9) @(negedge clk);
        write(8'd200);
        @(negedge clk);
        write(8'd45);
        @(negedge clk);
        write(8'd99);
        for (int i = 0; i < 12; i++) begin
            check("chain_busy", {7'd0, dis_busy}, 8'd1);
            @(negedge clk);
        end
        check("chain_idle", {7'd0, dis_busy}, 8'd0);
        wait_drain();

        // Reset four clocks into a 255 conversion
        write(8'd255);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", {4'h0, seg_sel}, 8'h0F);
        check("mid_rst_data", seg_data, 8'hFF);
        check("mid_rst_busy", {7'd0, dis_busy}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_sel", {4'h0, seg_sel}, 8'h0E);
        check("post_rst_data", seg_data, 8'hC0);
        repeat (10) @(negedge clk);
        check("post_rst_busy", {7'd0, dis_busy}, 8'd0);
        check_disp(8'hC0, ZB ? 8'hFF : 8'hC0, ZB ? 8'hFF : 8'hC0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
